// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the SRAM slave protocol state type.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

endpackage

// File: rtl/ahb3lite_sram_array.sv
// Single-port word-organised storage: byte-enable synchronous write, asynchronous read.
module ahb3lite_sram_array #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [WIDTH/8-1:0]       be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; clearing a RAM array would force it into flops.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WIDTH/8; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM slave with programmable wait states and two-cycle ERROR response.
// Optional user-access rejection when AHB3LITE_SRAM_PRIV_CHECK_EN is defined.
module ahb3lite_sram_slave
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE  = 16,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int         BYTES      = HDATA_SIZE / 8;
   localparam int         LOG2_BYTES = $clog2(BYTES);
   localparam int         IDX_W      = $clog2(MEM_DEPTH);
   localparam logic [2:0] MAX_SIZE   = 3'(LOG2_BYTES);
   localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);

   state_t                  state, state_nxt;
   logic [3:0]              wait_cnt, wait_cnt_nxt;
   logic [HADDR_SIZE-1:0]   addr_q;
   logic [2:0]              size_q;
   logic                    write_q;
   logic [HDATA_SIZE-1:0]   hrdata_q, mem_rdata;
   logic [BYTES-1:0]        be;
   logic                    ready_int, accept, legal, misaligned, priv_ok;
   logic                    mem_we, rd_phase;

   assign ready_int = (state != ST_WAIT) && (state != ST_ERR1);
   assign accept    = HSEL && HREADY && ready_int &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

`ifdef AHB3LITE_SRAM_PRIV_CHECK_EN
   assign priv_ok = HPROT[1];
`else
   assign priv_ok = 1'b1;
`endif

   // Only the bits below a legal size can be misaligned; wider sizes fail the size check.
   always_comb begin
      misaligned = 1'b0;
      for (int b = 0; b < LOG2_BYTES; b++) begin
         if ((b < int'(HSIZE)) && HADDR[b]) misaligned = 1'b1;
      end
   end

   assign legal = (HSIZE <= MAX_SIZE) && !misaligned && priv_ok;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         ST_WAIT: begin
            if (wait_cnt <= 4'd1) begin
               state_nxt    = ST_DATA;
               wait_cnt_nxt = 4'd0;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: begin
            if (!accept) begin
               state_nxt = ST_IDLE;
            end else if (!legal) begin
               state_nxt = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = WAIT_LOAD;
            end else begin
               state_nxt = ST_DATA;
            end
         end
      endcase
   end

   assign rd_phase = (state == ST_DATA) && !write_q;
   assign mem_we   = (state == ST_DATA) && write_q;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         hrdata_q <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            addr_q  <= HADDR;
            size_q  <= HSIZE;
            write_q <= HWRITE;
         end
         if (rd_phase) hrdata_q <= mem_rdata;
      end
   end

   // A lane is enabled when it shares the latched address bits at and above the transfer size.
   always_comb begin
      be = '1;
      for (int i = 0; i < BYTES; i++) begin
         for (int b = 0; b < LOG2_BYTES; b++) begin
            if ((b >= int'(size_q)) && (i[b] != addr_q[b])) be[i] = 1'b0;
         end
      end
   end

   ahb3lite_sram_array #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (HDATA_SIZE)
   ) u_array (
      .clk   (HCLK),
      .we    (mem_we),
      .be    (be),
      .addr  (addr_q[LOG2_BYTES +: IDX_W]),
      .wdata (HWDATA),
      .rdata (mem_rdata)
   );

   assign HREADYOUT = ready_int;
   assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA    = rd_phase ? mem_rdata : hrdata_q;

   logic unused_ok;
   assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, addr_q};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Scoreboard bench for ahb3lite_sram_slave: one zero-wait and one two-wait instance.
// Expectations follow AHB3LITE_SRAM_PRIV_CHECK_EN when it is defined.
module tb_ahb3lite_sram_slave;
   import ahb3lite_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam logic [3:0] PRIV = 4'b0011;
   localparam logic [3:0] USER = 4'b0001;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic [1:0]    hsel;
   logic [AW-1:0] haddr;
   logic [DW-1:0] hwdata;
   logic          hwrite;
   logic [2:0]    hsize, hburst;
   logic [3:0]    hprot;
   logic [1:0]    htrans;
   logic          hmastlock;
   logic [DW-1:0] hrdata0, hrdata2;
   logic          hreadyout0, hreadyout2, hresp0, hresp2;

   always #5 HCLK = ~HCLK;

   ahb3lite_sram_slave #(.WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hreadyout0), .HREADYOUT(hreadyout0),
      .HRESP(hresp0));

   ahb3lite_sram_slave #(.WAIT_STATES(2)) dut2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrdata2), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hreadyout2), .HREADYOUT(hreadyout2),
      .HRESP(hresp2));

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [2:0]    size;
      logic [DW-1:0] wdata;
      logic [3:0]    prot;
   } cmd_t;

   typedef struct {
      logic          write;
      logic          err;
      logic [DW-1:0] rdata;
      int            waits;
   } exp_t;

   cmd_t          cmds[$];
   exp_t          sb[$];
   logic [7:0]    model [2][4096];
   logic [DW-1:0] last_rd [2];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic add(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz,
                      input logic [DW-1:0] d, input logic [3:0] p);
      cmd_t c;
      c.write = wr; c.addr = a; c.size = sz; c.wdata = d; c.prot = p;
      cmds.push_back(c);
   endtask

   // Reference model: legality, wait count, byte-lane write and full-word read data.
   task automatic predict(input int tgt, input cmd_t c, output exp_t e);
      int nb, base, word;
      nb    = 1 << int'(c.size);
      base  = int'(c.addr) & 4095;
      word  = base & ~3;
      e.write = c.write;
      e.rdata = '0;
      e.err   = (c.size > 3'd2) || ((base & (nb - 1)) != 0);
`ifdef AHB3LITE_SRAM_PRIV_CHECK_EN
      if (c.prot[1] == 1'b0) e.err = 1'b1;
`endif
      e.waits = e.err ? 1 : ((tgt == 0) ? 0 : 2);
      if (!e.err) begin
         if (c.write) begin
            for (int b = 0; b < nb; b++)
               model[tgt][base + b] = c.wdata[8*((base + b) & 3) +: 8];
         end else begin
            e.rdata = {model[tgt][word + 3], model[tgt][word + 2],
                       model[tgt][word + 1], model[tgt][word]};
         end
      end
   endtask

   task automatic drive_addr(input int tgt, input cmd_t c);
      hsel   = (tgt == 0) ? 2'b01 : 2'b10;
      htrans = HTRANS_NONSEQ;
      haddr  = c.addr;
      hwrite = c.write;
      hsize  = c.size;
      hprot  = c.prot;
   endtask

   task automatic drive_idle(input int tgt);
      hsel   = (tgt == 0) ? 2'b01 : 2'b10;
      htrans = HTRANS_IDLE;
      hwrite = 1'b0;
   endtask

   // Issues the queued commands back-to-back and checks every data phase against the scoreboard.
   task automatic run_cmds(input int tgt);
      exp_t          e;
      cmd_t          bus_cmd;
      int            nxt, low, guard;
      bit            pend, busy;
      logic          rdy, rsp;
      logic [DW-1:0] rd;
      low = 0; guard = 0; busy = 0;
      @(posedge HCLK); #1;
      bus_cmd = cmds[0];
      predict(tgt, bus_cmd, e);
      sb.push_back(e);
      drive_addr(tgt, bus_cmd);
      pend = 1; nxt = 1;
      forever begin
         @(negedge HCLK);
         rdy = (tgt == 0) ? hreadyout0 : hreadyout2;
         rsp = (tgt == 0) ? hresp0 : hresp2;
         rd  = (tgt == 0) ? hrdata0 : hrdata2;
         if (busy) begin
            if (!rdy) begin
               low++;
               check("resp_stall", {63'd0, rsp}, {63'd0, sb[0].err});
            end else begin
               e = sb.pop_front();
               check("wait_cycles", 64'(low), 64'(e.waits));
               check("resp", {63'd0, rsp}, {63'd0, e.err});
               if (!e.write && !e.err) begin
                  check("rdata", 64'(rd), 64'(e.rdata));
                  last_rd[tgt] = e.rdata;
               end
               busy = 0;
            end
         end
         guard++;
         if (guard > 200) begin
            checks++; errors++;
            $error("FAIL timeout observed=%0d expected=<200 cycles", guard);
            break;
         end
         if (!pend && !busy) break;
         @(posedge HCLK); #1;
         if (rdy && pend) begin
            busy   = 1;
            low    = 0;
            hwdata = bus_cmd.wdata;
            if (nxt < cmds.size()) begin
               bus_cmd = cmds[nxt];
               nxt++;
               predict(tgt, bus_cmd, e);
               sb.push_back(e);
               drive_addr(tgt, bus_cmd);
            end else begin
               pend = 0;
               drive_idle(tgt);
            end
         end
      end
      // Selected IDLE transfer: zero-wait OKAY, read data held.
      @(negedge HCLK);
      check("idle_ready", {63'd0, (tgt == 0) ? hreadyout0 : hreadyout2}, 64'd1);
      check("idle_resp", {63'd0, (tgt == 0) ? hresp0 : hresp2}, 64'd0);
      check("hrdata_hold", 64'((tgt == 0) ? hrdata0 : hrdata2), 64'(last_rd[tgt]));
      hsel = 2'b00;
      cmds.delete();
   endtask

   initial begin
      cmd_t c;
      hsel = 2'b00; htrans = HTRANS_IDLE; haddr = '0; hwdata = '0; hwrite = 1'b0;
      hsize = HSIZE_WORD; hburst = 3'b000; hprot = PRIV; hmastlock = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;

      repeat (3) @(posedge HCLK);
      #1;
      check("rst_ready0", {63'd0, hreadyout0}, 64'd1);
      check("rst_resp0", {63'd0, hresp0}, 64'd0);
      check("rst_rdata0", 64'(hrdata0), 64'd0);
      check("rst_ready2", {63'd0, hreadyout2}, 64'd1);
      check("rst_resp2", {63'd0, hresp2}, 64'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Zero-wait write then back-to-back read, plus an aliased read of the same word.
      add(1'b1, 16'h0010, HSIZE_WORD, 32'hDEADBEEF, PRIV);
      add(1'b0, 16'h0010, HSIZE_WORD, '0, PRIV);
      add(1'b0, 16'h1010, HSIZE_WORD, '0, PRIV);
      run_cmds(0);

      // Two wait states on every accepted transfer.
      add(1'b1, 16'h0004, HSIZE_WORD, 32'hA5A50F0F, PRIV);
      add(1'b0, 16'h0004, HSIZE_WORD, '0, PRIV);
      run_cmds(1);

      // Byte-lane writes assemble a word; halfword overwrite of the upper half.
      add(1'b1, 16'h0020, HSIZE_BYTE, 32'h00000011, PRIV);
      add(1'b1, 16'h0021, HSIZE_BYTE, 32'h00002200, PRIV);
      add(1'b1, 16'h0022, HSIZE_BYTE, 32'h00330000, PRIV);
      add(1'b1, 16'h0023, HSIZE_BYTE, 32'h44000000, PRIV);
      add(1'b0, 16'h0020, HSIZE_WORD, '0, PRIV);
      add(1'b1, 16'h0022, HSIZE_HWORD, 32'hBEEF0000, PRIV);
      add(1'b0, 16'h0020, HSIZE_WORD, '0, PRIV);
      run_cmds(0);

      // Misaligned halfword and oversize transfer both take the ERROR response, memory untouched.
      add(1'b1, 16'h0030, HSIZE_WORD, 32'h55AA55AA, PRIV);
      add(1'b1, 16'h0031, HSIZE_HWORD, 32'hFFFFFFFF, PRIV);
      add(1'b1, 16'h0030, HSIZE_DWORD, 32'h12121212, PRIV);
      add(1'b1, 16'h0032, HSIZE_WORD, 32'h34343434, PRIV);
      add(1'b0, 16'h0030, HSIZE_WORD, '0, PRIV);
      run_cmds(0);
      add(1'b1, 16'h0030, HSIZE_WORD, 32'h0BADF00D, PRIV);
      add(1'b1, 16'h0031, HSIZE_HWORD, 32'hFFFFFFFF, PRIV);
      add(1'b0, 16'h0030, HSIZE_WORD, '0, PRIV);
      run_cmds(1);

      // User-mode accesses: rejected only with the privilege check built in.
      add(1'b1, 16'h0050, HSIZE_WORD, 32'h01234567, PRIV);
      add(1'b1, 16'h0050, HSIZE_WORD, 32'h89ABCDEF, USER);
      add(1'b0, 16'h0050, HSIZE_WORD, '0, PRIV);
      add(1'b1, 16'h0050, HSIZE_WORD, 32'h89ABCDEF, PRIV);
      add(1'b0, 16'h0050, HSIZE_WORD, '0, PRIV);
      run_cmds(0);

      // Reset during a WAIT cycle abandons the pending write.
      add(1'b1, 16'h0040, HSIZE_WORD, 32'hCAFEF00D, PRIV);
      add(1'b0, 16'h0040, HSIZE_WORD, '0, PRIV);
      run_cmds(1);
      @(posedge HCLK); #1;
      c.write = 1'b1; c.addr = 16'h0040; c.size = HSIZE_WORD; c.wdata = 32'h12345678; c.prot = PRIV;
      drive_addr(1, c);
      @(posedge HCLK); #1;
      hwdata = c.wdata;
      drive_idle(1);
      hsel = 2'b00;
      @(negedge HCLK);
      check("wait_before_rst", {63'd0, hreadyout2}, 64'd0);
      HRESETn = 1'b0;
      #1;
      check("rst_mid_ready", {63'd0, hreadyout2}, 64'd1);
      check("rst_mid_resp", {63'd0, hresp2}, 64'd0);
      check("rst_mid_rdata", 64'(hrdata2), 64'd0);
      last_rd[0] = '0; last_rd[1] = '0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      add(1'b0, 16'h0040, HSIZE_WORD, '0, PRIV);
      run_cmds(1);

      repeat (2) @(posedge HCLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
